// File: rtl/mem_stage_if.sv
// Data-cache request bus between the MEM stage and the D-cache.
// master = pipeline stage, slave = cache side.
interface mem_stage_if;
   logic        dmemREN;
   logic        dmemWEN;
   logic [31:0] dmemaddr;
   logic [31:0] dmemstore;
   logic [31:0] dmemload;
   logic        dhit;

   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore,
      input  dmemload, dhit
   );

   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore,
      output dmemload, dhit
   );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: D-cache request FSM, MEM/WB latch, halt.
// Define LLSC_EN to build the LL/SC link register.
module mem_stage (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        exm_valid,
   input  logic        exm_DRen,
   input  logic        exm_DWen,
   input  logic        exm_RegW,
   input  logic        exm_halt,
   input  logic        exm_ll,
   input  logic        exm_sc,
   input  logic [31:0] exm_alu_out,
   input  logic [31:0] exm_rdat2,
   input  logic [31:0] exm_npc,
   input  logic [4:0]  exm_wsel,
   input  logic [1:0]  exm_Mem,
   input  logic        ccinv,
   input  logic [31:0] ccsnoopaddr,
   mem_stage_if.master dmem,
   output logic        mem_stall,
   output logic        wb_valid,
   output logic        wb_RegW,
   output logic        wb_halt,
   output logic [4:0]  wb_wsel,
   output logic [31:0] wb_wdat
);

   typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_e;

   state_e      state_q, state_d;
   logic        ren_q, wen_q;
   logic [31:0] addr_q, data_q;
   logic        sc_ok;
   logic        req_now;
   logic        done;
   logic        sc_res;
   logic [31:0] wdat_d;

`ifdef LLSC_EN
   logic        link_valid_q;
   logic [31:0] link_addr_q;
   assign sc_ok = link_valid_q && (link_addr_q == exm_alu_out);
`else
   logic unused_llsc;
   assign unused_llsc = ^{exm_ll, exm_sc, ccinv, ccsnoopaddr};
   assign sc_ok = 1'b1;
`endif

   // A failing SC never reaches the cache.
   assign req_now = exm_valid & (exm_DRen | exm_DWen)
                  & ~(exm_sc & ~sc_ok);

   // Request drive, stall and next state; all gated by reset.
   always_comb begin
      dmem.dmemREN   = 1'b0;
      dmem.dmemWEN   = 1'b0;
      dmem.dmemaddr  = 32'h0;
      dmem.dmemstore = 32'h0;
      mem_stall      = 1'b0;
      done           = 1'b0;
      state_d        = state_q;
      case (state_q)
         IDLE: begin
            if (req_now) begin
               dmem.dmemREN   = exm_DRen;
               dmem.dmemWEN   = exm_DWen & ~exm_DRen;
               dmem.dmemaddr  = exm_alu_out;
               dmem.dmemstore = exm_rdat2;
               done           = dmem.dhit;
               mem_stall      = ~dmem.dhit;
               if (!dmem.dhit) state_d = WAIT;
            end else begin
               done = 1'b1;
            end
         end
         WAIT: begin
            dmem.dmemREN   = ren_q;
            dmem.dmemWEN   = wen_q;
            dmem.dmemaddr  = addr_q;
            dmem.dmemstore = data_q;
            done           = dmem.dhit;
            mem_stall      = ~dmem.dhit;
            if (dmem.dhit) state_d = IDLE;
         end
         default: ;
      endcase
      if (done && exm_valid && exm_halt) state_d = HALTED;
      if (!nRST) begin
         dmem.dmemREN   = 1'b0;
         dmem.dmemWEN   = 1'b0;
         dmem.dmemaddr  = 32'h0;
         dmem.dmemstore = 32'h0;
         mem_stall      = 1'b0;
         done           = 1'b0;
      end
   end

   // Only a successful SC issues a request, so WAIT implies result 1.
   always_comb begin
      sc_res = (state_q == WAIT) ? 1'b1 : sc_ok;
      wdat_d = exm_alu_out;
      unique case (exm_Mem)
         2'b00: wdat_d = exm_alu_out;
         2'b01: wdat_d = dmem.dmemload;
         2'b10: wdat_d = exm_npc;
         2'b11: wdat_d = {31'h0, sc_res};
      endcase
   end

   // FSM state and captured request for the WAIT state.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         addr_q  <= 32'h0;
         data_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req_now && !dmem.dhit) begin
            ren_q  <= exm_DRen;
            wen_q  <= exm_DWen & ~exm_DRen;
            addr_q <= exm_alu_out;
            data_q <= exm_rdat2;
         end
      end
   end

   // MEM/WB latch: bubble while stalled or halted, sticky halt.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wb_valid <= 1'b0;
         wb_RegW  <= 1'b0;
         wb_halt  <= 1'b0;
         wb_wsel  <= 5'h0;
         wb_wdat  <= 32'h0;
      end else if (done) begin
         wb_valid <= exm_valid;
         wb_RegW  <= exm_valid & exm_RegW;
         wb_halt  <= wb_halt | (exm_valid & exm_halt);
         wb_wsel  <= exm_wsel;
         wb_wdat  <= wdat_d;
      end else begin
         wb_valid <= 1'b0;
         wb_RegW  <= 1'b0;
      end
   end

`ifdef LLSC_EN
   // Link register: snoop/store clears, LL completion sets last.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         link_valid_q <= 1'b0;
         link_addr_q  <= 32'h0;
      end else begin
         if (ccinv && ccsnoopaddr == link_addr_q)
            link_valid_q <= 1'b0;
         if (done && exm_valid) begin
            if (exm_sc)
               link_valid_q <= 1'b0;
            else if (exm_DWen && exm_alu_out == link_addr_q)
               link_valid_q <= 1'b0;
            if (exm_DRen && exm_ll) begin
               link_valid_q <= 1'b1;
               link_addr_q  <= exm_alu_out;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver pushes expected WB records,
// monitor pops and compares on every wb_valid.
module tb_mem_stage;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        exm_valid, exm_DRen, exm_DWen, exm_RegW;
   logic        exm_halt, exm_ll, exm_sc;
   logic [31:0] exm_alu_out, exm_rdat2, exm_npc;
   logic [4:0]  exm_wsel;
   logic [1:0]  exm_Mem;
   logic        ccinv;
   logic [31:0] ccsnoopaddr;
   logic        mem_stall, wb_valid, wb_RegW, wb_halt;
   logic [4:0]  wb_wsel;
   logic [31:0] wb_wdat;

   mem_stage_if bus ();

   mem_stage dut (
      .CLK(CLK), .nRST(nRST),
      .exm_valid(exm_valid), .exm_DRen(exm_DRen), .exm_DWen(exm_DWen),
      .exm_RegW(exm_RegW), .exm_halt(exm_halt), .exm_ll(exm_ll),
      .exm_sc(exm_sc), .exm_alu_out(exm_alu_out), .exm_rdat2(exm_rdat2),
      .exm_npc(exm_npc), .exm_wsel(exm_wsel), .exm_Mem(exm_Mem),
      .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
      .dmem(bus.master),
      .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_RegW(wb_RegW),
      .wb_halt(wb_halt), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        regw;
      logic [4:0]  wsel;
      logic [31:0] wdat;
   } wb_t;

   wb_t exp_q[$];
   int  n_vec = 0;
   int  n_err = 0;

`ifdef LLSC_EN
   localparam logic SC2_OK = 1'b0;
`else
   localparam logic SC2_OK = 1'b1;
`endif

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: compare every WB output against the scoreboard.
   always @(posedge CLK) begin
      wb_t e;
      #2;
      if (nRST && wb_valid) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_wb: got wsel %0d wdat %h expected none",
                     wb_wsel, wb_wdat);
         end else begin
            e = exp_q.pop_front();
            chk("wb_RegW", {31'h0, wb_RegW}, {31'h0, e.regw});
            chk("wb_wsel", {27'h0, wb_wsel}, {27'h0, e.wsel});
            chk("wb_wdat", wb_wdat, e.wdat);
         end
      end
   end

   task automatic clr_in();
      exm_valid = 0; exm_DRen = 0; exm_DWen = 0; exm_RegW = 0;
      exm_halt = 0; exm_ll = 0; exm_sc = 0;
      exm_alu_out = 0; exm_rdat2 = 0; exm_wsel = 0; exm_Mem = 0;
      ccinv = 0; ccsnoopaddr = 0;
      bus.dhit = 0; bus.dmemload = 32'hBAD0BAD0;
   endtask

   task automatic set_op(input logic dren, dwen, regw, halt, ll, sc,
                         input logic [31:0] addr, wdata,
                         input logic [4:0] wsel, input logic [1:0] mem);
      exm_valid = 1; exm_DRen = dren; exm_DWen = dwen; exm_RegW = regw;
      exm_halt = halt; exm_ll = ll; exm_sc = sc;
      exm_alu_out = addr; exm_rdat2 = wdata;
      exm_wsel = wsel; exm_Mem = mem;
      ccinv = 0;
   endtask

   task automatic run_op(input logic dren, dwen, regw, halt, ll, sc,
                         input logic [31:0] addr, wdata, ldata,
                         input logic [4:0] wsel, input logic [1:0] mem,
                         input int lat, input logic xren, xwen,
                         input logic [31:0] xwdat);
      wb_t e;
      for (int c = 0; c <= lat; c++) begin
         @(negedge CLK);
         set_op(dren, dwen, regw, halt, ll, sc, addr, wdata, wsel, mem);
         bus.dhit = (c == lat);
         bus.dmemload = (c == lat) ? ldata : 32'hBAD0BAD0;
         #1;
         chk("dmemREN", {31'h0, bus.dmemREN}, {31'h0, xren});
         chk("dmemWEN", {31'h0, bus.dmemWEN}, {31'h0, xwen});
         chk("mem_stall", {31'h0, mem_stall},
             {31'h0, (c < lat) && (xren || xwen)});
         if (xren || xwen) chk("dmemaddr", bus.dmemaddr, addr);
         if (xwen) chk("dmemstore", bus.dmemstore, wdata);
         if (c == lat) begin
            e.regw = regw; e.wsel = wsel; e.wdat = xwdat;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic idle(input logic inv, input logic [31:0] snoop);
      @(negedge CLK);
      clr_in();
      ccinv = inv; ccsnoopaddr = snoop;
      #1;
      chk("idle_ren", {31'h0, bus.dmemREN}, 32'h0);
      chk("idle_stall", {31'h0, mem_stall}, 32'h0);
   endtask

   initial begin
      clr_in();
      exm_npc = 32'h0040_0104;
      nRST = 0;
      repeat (2) @(negedge CLK);
      set_op(1, 0, 1, 0, 0, 0, 32'h100, 0, 5'd1, 2'b01);
      #1;
      chk("rst_ren", {31'h0, bus.dmemREN}, 32'h0);
      chk("rst_stall", {31'h0, mem_stall}, 32'h0);
      chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
      chk("rst_wb_halt", {31'h0, wb_halt}, 32'h0);
      chk("rst_wb_wdat", wb_wdat, 32'h0);
      @(negedge CLK);
      clr_in();
      nRST = 1;

      // ALU op, writeback of alu_out
      run_op(0, 0, 1, 0, 0, 0, 32'h1234_5678, 0, 0, 5'd3, 2'b00,
             0, 0, 0, 32'h1234_5678);
      // LW 0x100, dhit three cycles later
      run_op(1, 0, 1, 0, 0, 0, 32'h100, 0, 32'hCAFE_F00D, 5'd5, 2'b01,
             3, 1, 0, 32'hCAFE_F00D);
      // SW 0x40 hit same cycle, no reg write
      run_op(0, 1, 0, 0, 0, 0, 32'h40, 32'hDEAD_BEEF, 0, 5'd0, 2'b00,
             0, 0, 1, 32'h40);
      idle(0, 0);
      // JAL-style npc writeback
      run_op(0, 0, 1, 0, 0, 0, 32'h7, 0, 0, 5'd31, 2'b10,
             0, 0, 0, 32'h0040_0104);
      // SW with two wait cycles
      run_op(0, 1, 0, 0, 0, 0, 32'h84, 32'h0BAD_CAFE, 0, 5'd0, 2'b00,
             2, 0, 1, 32'h84);
      // LL then SC to 0x200: store issued, result 1
      run_op(1, 0, 1, 0, 1, 0, 32'h200, 0, 32'h11, 5'd6, 2'b01,
             0, 1, 0, 32'h11);
      run_op(0, 1, 1, 0, 0, 1, 32'h200, 32'h77, 0, 5'd7, 2'b11,
             1, 0, 1, 32'h1);
      // LL, snoop invalidate, SC
      run_op(1, 0, 1, 0, 1, 0, 32'h200, 0, 32'h22, 5'd6, 2'b01,
             0, 1, 0, 32'h22);
      idle(1, 32'h200);
      run_op(0, 1, 1, 0, 0, 1, 32'h200, 32'h88, 0, 5'd8, 2'b11,
             0, 0, SC2_OK, {31'h0, SC2_OK});
      idle(0, 0);

      // reset while waiting on a load
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         set_op(1, 0, 1, 0, 0, 0, 32'h300, 0, 5'd9, 2'b01);
         bus.dhit = 0;
         #1;
         chk("wait_ren", {31'h0, bus.dmemREN}, 32'h1);
         chk("wait_stall", {31'h0, mem_stall}, 32'h1);
      end
      @(negedge CLK);
      nRST = 0;
      #1;
      chk("rstwait_ren", {31'h0, bus.dmemREN}, 32'h0);
      chk("rstwait_stall", {31'h0, mem_stall}, 32'h0);
      chk("rstwait_wbv", {31'h0, wb_valid}, 32'h0);
      @(negedge CLK);
      clr_in();
      nRST = 1;
      run_op(1, 0, 1, 0, 0, 0, 32'h300, 0, 32'h3333_0000, 5'd9, 2'b01,
             1, 1, 0, 32'h3333_0000);

      // halt, then a load that must be ignored
      run_op(0, 0, 0, 1, 0, 0, 32'h55, 0, 0, 5'd0, 2'b00,
             0, 0, 0, 32'h55);
      @(negedge CLK);
      clr_in();
      chk("wb_halt", {31'h0, wb_halt}, 32'h1);
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         set_op(1, 0, 1, 0, 0, 0, 32'h100, 0, 5'd4, 2'b01);
         bus.dhit = 1;
         #1;
         chk("halt_ren", {31'h0, bus.dmemREN}, 32'h0);
         chk("halt_stall", {31'h0, mem_stall}, 32'h0);
      end
      @(negedge CLK);
      clr_in();
      repeat (2) @(negedge CLK);
      chk("halt_sticky", {31'h0, wb_halt}, 32'h1);
      chk("sb_empty", exp_q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
